angle_bcd_converter: RTL

ANGLE_BCD_CONVERTER -- requirements
Module: angle_bcd_converter

---
 rtl/angle_bcd_converter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/angle_bcd_converter.sv
// Sector code to angle converter: latches (code*STEP_DEG) mod WRAP_DEG, then converts
// the binary angle to BCD with a one-bit-per-clock shift-add-3 engine.
module angle_bcd_converter #(
    parameter int CODE_W   = 3,
    parameter int STEP_DEG = 45,
    parameter int WRAP_DEG = 360,
    parameter int DEG_W    = 9,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CODE_W-1:0]     code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEG_W-1:0]      degrees,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int PROD_W = CODE_W + $clog2(STEP_DEG + 1);
    // Wide enough for both the full product and the modulus itself.
    localparam int MOD_W  = (PROD_W > DEG_W + 1) ? PROD_W : DEG_W + 1;
    localparam int CNT_W  = $clog2(DEG_W + 1);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int unsigned LIMIT = 10 ** DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [DEG_W-1:0]   angle_reg;
    logic [DEG_W-1:0]   shift_reg;
    logic [BCD_W-1:0]   work_reg;
    logic [CNT_W-1:0]   count_reg;

    logic [MOD_W-1:0]   wide_product;
    logic [DEG_W-1:0]   angle_next;
    logic [BCD_W-1:0]   adj_bcd;
    logic [BCD_W-1:0]   shifted_bcd;
    logic [DEG_W-1:0]   shifted_bin;
    logic               accept;
    logic               drain;
    logic               last_step;
    logic               ovf_now;

    assign wide_product = MOD_W'(code) * MOD_W'(STEP_DEG);
    assign angle_next   = DEG_W'(wide_product % MOD_W'(WRAP_DEG));

    // Add-3 correction on every digit that would exceed 9 after doubling.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj_bcd[gi*4 +: 4] = (work_reg[gi*4 +: 4] >= 4'd5)
                                        ? work_reg[gi*4 +: 4] + 4'd3
                                        : work_reg[gi*4 +: 4];
        end
    endgenerate

    assign shifted_bcd = BCD_W'({adj_bcd, shift_reg[DEG_W-1]});
    assign shifted_bin = {shift_reg[DEG_W-2:0], 1'b0};
    assign last_step   = (count_reg == CNT_W'(DEG_W - 1));
    assign ovf_now     = (32'(angle_reg) >= LIMIT);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        drain      = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                drain     = out_ready;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_reg <= '0;
            shift_reg <= '0;
            work_reg  <= '0;
            count_reg <= '0;
            degrees   <= '0;
            bcd       <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            angle_reg <= angle_next;
            shift_reg <= angle_next;
            work_reg  <= '0;
            count_reg <= '0;
        end else if (state_reg == CONV) begin
            shift_reg <= shifted_bin;
            work_reg  <= shifted_bcd;
            count_reg <= count_reg + 1'b1;
            if (last_step) begin
                degrees  <= angle_reg;
                overflow <= ovf_now;
                bcd      <= ovf_now ? {DIGITS{4'b1001}} : shifted_bcd;
            end
        end
    end

endmodule
